fifo_flex: RTL and testbench
============================

Name: fifo_flex

Overview:
- Parametrised successor to the fixed 16x8 FIFO: configurable data width, any depth >= 2 (power of two not required), and a selectable overflow policy (drop or overwrite-oldest).
- Adds almost-full/almost-empty thresholds, registered overflow/underflow event pulses, and a synchronous flush.
- Sits between a producer and a consumer in the same clock domain. Read is asynchronous (first-word fall-through); write is synchronous.

Parameters:
- WIDTH, 8, data width in bits (>= 1).
- DEPTH, 16, number of entries (>= 2).
- OVF_MODE, OVF_DROP, full-write policy from fifo_pkg: OVF_DROP rejects the write; OVF_OVERWRITE replaces the oldest entry.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- Derived, not overridable: AW = max(1, $clog2(DEPTH)); CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; highest priority after reset.
- wen  in  1  write request.
- wdata  in  WIDTH  write data.
- ren  in  1  read request; pops the entry currently shown on rdata.
- rdata  out  WIDTH  mem[raddr], combinational.
- count  out  CW  number of valid entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  (count == 0) && rst_n.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  (count <= AE_LEVEL) && rst_n.
- overflow  out  1  registered one-cycle pulse: a write hit a full FIFO.
- underflow  out  1  registered one-cycle pulse: a read hit an empty FIFO.

Behaviour:
- Reset (rst_n low): waddr, raddr, count, overflow and underflow are 0 immediately.
  - full = 0, empty = 0, almost_empty = 0, almost_full = 0 (AF_LEVEL >= 1).
  - Memory contents are not reset.
- Per-cycle priority: reset > clr > normal operation.
- clr: next cycle waddr = raddr = count = 0 and overflow = underflow = 0. Any wen/ren in that cycle is discarded and flags nothing.
- Let do_w and do_r be the effective write and read:
  - count == 0: do_r = 0. If ren, underflow = 1 next cycle. do_w = wen. rdata is don't-care.
  - 0 < count < DEPTH: do_w = wen, do_r = ren.
  - count == DEPTH and ren: do_w = wen, do_r = 1. Count is unchanged if both; no overflow.
  - count == DEPTH, wen, !ren, OVF_DROP: write discarded; pointers and count unchanged; overflow = 1 next cycle.
  - count == DEPTH, wen, !ren, OVF_OVERWRITE: mem[waddr] <= wdata; waddr and raddr both advance; count stays DEPTH; overflow = 1 next cycle.
- A write to an empty FIFO with ren also high: the write lands, the read is ignored, count becomes 1, underflow pulses.
- Pointers increment modulo DEPTH: value DEPTH-1 wraps to 0, never reaching DEPTH. Invariant: waddr < DEPTH and raddr < DEPTH.
- count: +1 on do_w && !do_r, -1 on do_r && !do_w, otherwise unchanged. Never exceeds DEPTH and never underflows.
- Invariant: count == (waddr - raddr) mod DEPTH, or count == DEPTH with waddr == raddr.
- Write-to-read latency is 1 cycle: data written at edge N is on rdata after edge N when the FIFO was empty.
- count changes by at most 1 per cycle, except clr/reset to 0.
- overflow/underflow are single-cycle registered pulses: high for exactly one cycle after each offending request, not sticky.
- Parameter legality is checked at elaboration; an illegal AF_LEVEL or AE_LEVEL is a fatal error.

Decomposition:
- fifo_pkg:
  - ovf_mode_t enum {OVF_DROP=0, OVF_OVERWRITE=1}.
  - Function addr_w(depth) returning max(1, $clog2(depth)).
  - Function cnt_w(depth) returning $clog2(depth+1).
- Sub-module fifo_ptr #(DEPTH):
  - Ports: clk, rst_n, clr, inc, ptr[AW].
  - Modulo-DEPTH counter with async reset and sync clear.
  - Instantiated twice: write pointer driven by do_w; read pointer driven by do_r, or by the overwrite skip in OVF_OVERWRITE mode.
- Memory, count and flags stay in fifo_flex.
- Formal block under FORMAL:
  - assume rst_n stays high once released.
  - assert the pointer and count invariants above.
  - cover full, empty, overflow and wrap.

Test Plan (WIDTH=8, DEPTH=16 unless stated):
- Reset, then 16 writes 0x00..0x0F -> full = 1 and count = 16 at cycle 16; almost_full first high after the 14th write; 16 reads return 0x00..0x0F in order; then empty = 1.
- OVF_DROP, full FIFO, write 0xAA with ren = 0 -> count stays 16, overflow high exactly one cycle; next 16 reads return 0x00..0x0F; 0xAA never appears.
- OVF_OVERWRITE, full FIFO, write 0xAA -> count 16, overflow pulse, raddr advances; reads return 0x01..0x0F then 0xAA.
- Empty FIFO, wen = 1 and ren = 1 with wdata = 0x55 -> count = 1, underflow pulse, rdata = 0x55 next cycle; ren alone on empty -> underflow, count stays 0.
- DEPTH=5: 12 write/read pairs -> pointers wrap 4 to 0 and never reach 5; data order preserved; count never exceeds 5.
- Mid-operation events:
  - clr at count 7 with wen = 1 -> count = 0, empty = 1 next cycle, no flags.
  - rst_n low mid-burst -> count = 0 and empty = 0 immediately; empty = 1 after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the flexible FIFO and its pointer counters.
package fifo_pkg;

  typedef enum logic {
    OVF_DROP      = 1'b0,
    OVF_OVERWRITE = 1'b1
  } ovf_mode_t;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_flex_props.sv
// Formal-only properties for fifo_flex: pointer/count invariants and reachability covers.
`ifdef FORMAL
module fifo_flex_props #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 5
) (
  input logic          clk,
  input logic          rst_n,
  input logic [AW-1:0] waddr,
  input logic [AW-1:0] raddr,
  input logic [CW-1:0] count,
  input logic          full,
  input logic          empty,
  input logic          overflow
);

  int diff_s;
  assign diff_s = (int'(waddr) - int'(raddr) + DEPTH) % DEPTH;

  assume property (@(posedge clk) rst_n |=> rst_n);

  assert property (@(posedge clk) disable iff (!rst_n) (int'(waddr) < DEPTH) && (int'(raddr) < DEPTH));
  assert property (@(posedge clk) disable iff (!rst_n) int'(count) <= DEPTH);
  assert property (@(posedge clk) disable iff (!rst_n)
    (int'(count) == DEPTH) ? (waddr == raddr) : (int'(count) == diff_s));

  cover property (@(posedge clk) full);
  cover property (@(posedge clk) rst_n && empty);
  cover property (@(posedge clk) overflow);
  cover property (@(posedge clk) disable iff (!rst_n)
    (int'(waddr) == DEPTH - 1) ##1 (waddr == {AW{1'b0}}));

endmodule
`endif

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer with asynchronous reset and synchronous clear.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] ptr_d;
  logic [AW-1:0] ptr_q;

  // Next pointer: clear wins, then wrap from DEPTH-1 straight back to zero.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = {AW{1'b0}};
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? {AW{1'b0}} : ptr_q + AW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {AW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flex.sv
// Parametrised same-clock FIFO with fall-through read, drop/overwrite overflow policy,
// almost-full/empty thresholds, event pulses and synchronous flush.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter  int        WIDTH    = 8,
  parameter  int        DEPTH    = 16,
  parameter  ovf_mode_t OVF_MODE = OVF_DROP,
  parameter  int        AF_LEVEL = DEPTH - 2,
  parameter  int        AE_LEVEL = 1,
  localparam int        AW       = addr_w(DEPTH),
  localparam int        CW       = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  if (WIDTH < 1 || DEPTH < 2) begin : g_bad_size
    $fatal(1, "fifo_flex: WIDTH must be >= 1 and DEPTH >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_flex: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_flex: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    waddr_s;
  logic [AW-1:0]    raddr_s;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             do_w_s, do_r_s, skip_s;
  logic             full_s, zero_s;

  assign full_s = (count_q == CW'(DEPTH));
  assign zero_s = (count_q == {CW{1'b0}});

  // Effective write/read, overwrite skip, event pulses and next count.
  always_comb begin
    do_w_s  = 1'b0;
    do_r_s  = 1'b0;
    skip_s  = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    count_d = count_q;
    if (clr) begin
      count_d = {CW{1'b0}};
    end else begin
      if (zero_s) begin
        do_w_s = wen;
        unf_d  = ren;
      end else if (full_s && wen && !ren) begin
        ovf_d = 1'b1;
        if (OVF_MODE == OVF_OVERWRITE) begin
          do_w_s = 1'b1;
          skip_s = 1'b1;
        end else begin
          do_w_s = 1'b0;
        end
      end else begin
        do_w_s = wen;
        do_r_s = ren;
      end
      // An overwrite replaces the oldest entry, so occupancy stays at DEPTH.
      if (do_w_s && !do_r_s && !skip_s) begin
        count_d = count_q + CW'(1);
      end else if (do_r_s && !do_w_s) begin
        count_d = count_q - CW'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (do_w_s),
    .ptr   (waddr_s)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (do_r_s | skip_s),
    .ptr   (raddr_s)
  );

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (do_w_s) begin
      mem_q[waddr_s] <= wdata;
    end
  end

  // Occupancy and event-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign rdata        = mem_q[raddr_s];
  assign count        = count_q;
  assign full         = full_s;
  assign empty        = zero_s && rst_n;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL)) && rst_n;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

`ifdef FORMAL
  fifo_flex_props #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) u_props (
    .clk      (clk),
    .rst_n    (rst_n),
    .waddr    (waddr_s),
    .raddr    (raddr_s),
    .count    (count_q),
    .full     (full_s),
    .empty    (empty),
    .overflow (ovf_q)
  );
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Directed self-checking bench for fifo_flex: drop and overwrite at DEPTH 16, wrap at DEPTH 5.
module tb_fifo_flex;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, clr;
  logic [7:0] wdata;
  logic       wen_a, ren_a, wen_b, ren_b, wen_c, ren_c;

  logic [7:0] rdata_a, rdata_b, rdata_c;
  logic [4:0] count_a, count_b;
  logic [2:0] count_c;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic       full_c, empty_c, af_c, ae_c, ovf_c, unf_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_flex #(.WIDTH(8), .DEPTH(16), .OVF_MODE(OVF_DROP)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen_a), .wdata(wdata), .ren(ren_a),
    .rdata(rdata_a), .count(count_a), .full(full_a), .empty(empty_a),
    .almost_full(af_a), .almost_empty(ae_a), .overflow(ovf_a), .underflow(unf_a));

  fifo_flex #(.WIDTH(8), .DEPTH(16), .OVF_MODE(OVF_OVERWRITE)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen_b), .wdata(wdata), .ren(ren_b),
    .rdata(rdata_b), .count(count_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b), .overflow(ovf_b), .underflow(unf_b));

  fifo_flex #(.WIDTH(8), .DEPTH(5), .OVF_MODE(OVF_DROP)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen_c), .wdata(wdata), .ren(ren_c),
    .rdata(rdata_c), .count(count_c), .full(full_c), .empty(empty_c),
    .almost_full(af_c), .almost_empty(ae_c), .overflow(ovf_c), .underflow(unf_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wdata = 8'h00;
    wen_a = 1'b0; ren_a = 1'b0; wen_b = 1'b0; ren_b = 1'b0; wen_c = 1'b0; ren_c = 1'b0;

    // Reset state
    #1;
    check("rst_count", count_a, 32'd0);
    check("rst_empty", empty_a, 32'd0);
    check("rst_full", full_a, 32'd0);
    check("rst_ae", ae_a, 32'd0);
    check("rst_af", af_a, 32'd0);
    check("rst_ovf", ovf_a, 32'd0);
    check("rst_unf", unf_a, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rel_empty", empty_a, 32'd1);
    check("rel_ae", ae_a, 32'd1);

    // Fill A with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wen_a = 1'b1; wdata = 8'(i);
      tick();
      check("fill_count", count_a, 32'(i + 1));
      check("fill_af", af_a, (i + 1 >= 14) ? 32'd1 : 32'd0);
      check("fill_ae", ae_a, (i + 1 <= 1) ? 32'd1 : 32'd0);
    end
    wen_a = 1'b0;
    check("fill_full", full_a, 32'd1);

    // Drop-mode overflow
    wen_a = 1'b1; wdata = 8'hAA;
    tick();
    wen_a = 1'b0;
    check("drop_count", count_a, 32'd16);
    check("drop_ovf", ovf_a, 32'd1);
    tick();
    check("drop_ovf_pulse", ovf_a, 32'd0);

    for (int i = 0; i < 16; i++) begin
      check("drop_rdata", rdata_a, 32'(i));
      ren_a = 1'b1;
      tick();
    end
    ren_a = 1'b0;
    check("drain_empty", empty_a, 32'd1);
    check("drain_count", count_a, 32'd0);
    check("drain_unf", unf_a, 32'd0);

    // Write+read on empty: write lands, read ignored, underflow pulses
    wen_a = 1'b1; ren_a = 1'b1; wdata = 8'h55;
    tick();
    wen_a = 1'b0; ren_a = 1'b0;
    check("wr_empty_count", count_a, 32'd1);
    check("wr_empty_unf", unf_a, 32'd1);
    check("wr_empty_rdata", rdata_a, 32'h55);
    tick();
    check("wr_empty_unf_pulse", unf_a, 32'd0);
    ren_a = 1'b1;
    tick();
    check("pop_one_count", count_a, 32'd0);
    check("pop_one_unf", unf_a, 32'd0);
    tick();
    ren_a = 1'b0;
    check("rd_empty_unf", unf_a, 32'd1);
    check("rd_empty_count", count_a, 32'd0);
    check("rd_empty_empty", empty_a, 32'd1);

    // Overwrite mode on B
    for (int i = 0; i < 16; i++) begin
      wen_b = 1'b1; wdata = 8'(i);
      tick();
    end
    check("ow_full", full_b, 32'd1);
    wdata = 8'hAA;
    tick();
    wen_b = 1'b0;
    check("ow_count", count_b, 32'd16);
    check("ow_ovf", ovf_b, 32'd1);
    check("ow_oldest", rdata_b, 32'h01);
    tick();
    check("ow_ovf_pulse", ovf_b, 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("ow_rdata", rdata_b, (i < 15) ? 32'(i + 1) : 32'hAA);
      ren_b = 1'b1;
      tick();
    end
    ren_b = 1'b0;
    check("ow_empty", empty_b, 32'd1);

    // DEPTH=5 wrap: prefill 3, then 12 simultaneous write/read pairs
    for (int i = 0; i < 3; i++) begin
      wen_c = 1'b1; wdata = 8'(8'h30 + i);
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      check("wrap_rdata", rdata_c, 32'(8'h30 + k));
      wen_c = 1'b1; ren_c = 1'b1; wdata = 8'(8'h33 + k);
      tick();
      check("wrap_count", count_c, 32'd3);
      check("wrap_wptr_range", (u_c.waddr_s < 3'd5) ? 32'd1 : 32'd0, 32'd1);
      check("wrap_rptr_range", (u_c.raddr_s < 3'd5) ? 32'd1 : 32'd0, 32'd1);
    end
    ren_c = 1'b0;
    wdata = 8'h40; tick();
    wdata = 8'h41; tick();
    check("c_full", full_c, 32'd1);
    check("c_count5", count_c, 32'd5);
    wdata = 8'h42; tick();
    wen_c = 1'b0;
    check("c_drop_count", count_c, 32'd5);
    check("c_drop_ovf", ovf_c, 32'd1);
    check("c_head", rdata_c, 32'h3C);

    // Flush at count 7 with a concurrent write
    for (int i = 0; i < 7; i++) begin
      wen_a = 1'b1; wdata = 8'(8'h70 + i);
      tick();
    end
    check("pre_clr_count", count_a, 32'd7);
    clr = 1'b1; wdata = 8'hEE;
    tick();
    clr = 1'b0; wen_a = 1'b0;
    check("clr_count", count_a, 32'd0);
    check("clr_empty", empty_a, 32'd1);
    check("clr_ovf", ovf_a, 32'd0);
    check("clr_unf", unf_a, 32'd0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) begin
      wen_a = 1'b1; wdata = 8'(i);
      tick();
    end
    check("pre_rst_count", count_a, 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", count_a, 32'd0);
    check("mid_rst_empty", empty_a, 32'd0);
    wen_a = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_empty", empty_a, 32'd1);
    check("post_rst_count", count_a, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
